// File: rtl/pl_pkg.sv
// rtl/pl_pkg.sv - shared state encoding and stage payload layout for the elastic pipeline stages
package pl_pkg;

    // State and occupancy share one encoding: the state value is the entry count.
    typedef enum logic [1:0] {
        PL_EMPTY = 2'd0,
        PL_ONE   = 2'd1,
        PL_FULL  = 2'd2
    } pl_state_e;

    // Payload widths per stage boundary of the RV32 pipeline.
    localparam int PL_IFID_W  = 64;   // pc + instr
    localparam int PL_IDEX_W  = 144;  // pc + rs1 + rs2 + imm + ctrl(16)
    localparam int PL_EXMEM_W = 88;   // alu + store data + rd(5) + ctrl(19)
    localparam int PL_MEMWB_W = 40;   // result + rd(5) + ctrl(3)

    // IF/ID field offsets
    localparam int PL_IFID_INSTR_LSB = 0;
    localparam int PL_IFID_PC_LSB    = 32;

    // ID/EX field offsets
    localparam int PL_IDEX_CTRL_LSB  = 0;
    localparam int PL_IDEX_IMM_LSB   = 16;
    localparam int PL_IDEX_RS2_LSB   = 48;
    localparam int PL_IDEX_RS1_LSB   = 80;
    localparam int PL_IDEX_PC_LSB    = 112;

    // EX/MEM field offsets
    localparam int PL_EXMEM_CTRL_LSB = 0;
    localparam int PL_EXMEM_RD_LSB   = 19;
    localparam int PL_EXMEM_STD_LSB  = 24;
    localparam int PL_EXMEM_ALU_LSB  = 56;

    // MEM/WB field offsets
    localparam int PL_MEMWB_CTRL_LSB = 0;
    localparam int PL_MEMWB_RD_LSB   = 3;
    localparam int PL_MEMWB_RES_LSB  = 8;

endpackage

// File: rtl/pl_data_reg.sv
// rtl/pl_data_reg.sv - payload register with load enable and synchronous clear
// Ports: clk; clr (sync clear to zero, wins over load); load; d (next payload); q (held payload).
module pl_data_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pl_elastic_stage.sv
// rtl/pl_elastic_stage.sv - valid/ready pipeline stage register with optional two-entry skid buffer
// Ports: clk; reset (sync, active-high); flush (squash held entries);
//        in_valid/in_ready/in_data (upstream side); out_valid/out_ready/out_data (downstream side);
//        occupancy (live entries, 0..2).
// SKID=1 registers in_ready and absorbs one extra beat in the skid register;
// SKID=0 uses a single register and a combinational in_ready.
module pl_elastic_stage
    import pl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pl_state_e         state_q;
    pl_state_e         state_d;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              skid_load;
    logic              sel_skid;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign out_valid = (state_q != PL_EMPTY);
    assign out_xfer  = out_valid & out_ready;
    assign in_xfer   = in_valid & in_ready;
    assign occupancy = state_q;
    assign out_data  = main_q;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        sel_skid  = 1'b0;
        if (flush) begin
            // Entries are squashed; payload registers keep their old contents.
            state_d = PL_EMPTY;
        end else if (SKID != 0) begin
            case (state_q)
                PL_EMPTY: begin
                    if (in_xfer) begin
                        state_d   = PL_ONE;
                        main_load = 1'b1;
                    end
                end
                PL_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d = PL_EMPTY;
                    end else if (in_xfer) begin
                        state_d   = PL_FULL;
                        skid_load = 1'b1;
                    end
                end
                PL_FULL: begin
                    // in_ready is low here, so only the drain case exists.
                    if (out_xfer) begin
                        state_d   = PL_ONE;
                        main_load = 1'b1;
                        sel_skid  = 1'b1;
                    end
                end
                default: state_d = PL_EMPTY;
            endcase
        end else begin
            if (in_xfer) begin
                state_d   = PL_ONE;
                main_load = 1'b1;
            end else if (out_xfer) begin
                state_d = PL_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PL_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d = sel_skid ? skid_q : in_data;

    pl_data_reg #(.DATA_W(DATA_W)) u_main (
        .clk  (clk),
        .clr  (reset),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // Registered ready looks at the next state so it drops on the
            // same edge the skid register fills.
            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != PL_FULL);
                end
            end
            assign in_ready = in_ready_q;

            pl_data_reg #(.DATA_W(DATA_W)) u_skid (
                .clk  (clk),
                .clr  (reset),
                .load (skid_load),
                .d    (in_data),
                .q    (skid_q)
            );
        end else begin : g_noskid
            logic unused_skid_load;
            assign unused_skid_load = skid_load;
            assign in_ready = out_ready | ~out_valid;
            assign skid_q   = '0;
        end
    endgenerate

endmodule
